// File: rtl/ram_burst_master.sv
// Burst initiator for a single-port synchronous RAM: turns valid/ready burst commands
// into registered CS/WE/OE strobes, streaming write beats in and read beats out.
module ram_burst_master #(
  parameter int DATA_SIZE = 8,
  parameter int DEPTH     = 64,
  parameter int LEN_W     = 6,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [AW-1:0]        cmd_addr,
  input  logic [LEN_W-1:0]     cmd_len,
  input  logic                 wdata_valid,
  output logic                 wdata_ready,
  input  logic [DATA_SIZE-1:0] wdata,
  output logic                 rdata_valid,
  input  logic                 rdata_ready,
  output logic [DATA_SIZE-1:0] rdata,
  output logic                 rdata_last,
  output logic                 busy,
  output logic                 ram_cs,
  output logic                 ram_wr_en,
  output logic                 ram_out_en,
  output logic [AW-1:0]        ram_addr,
  output logic [DATA_SIZE-1:0] ram_wdata,
  input  logic [DATA_SIZE-1:0] ram_rdata
);

  typedef enum logic [2:0] {IDLE, W_DATA, R_ISSUE, R_CAP, R_RSP} state_t;

  state_t           state;
  logic [AW-1:0]    cur_addr;
  logic [LEN_W-1:0] remaining;
  logic [AW-1:0]    cur_inc;

  // Explicit wrap so a non-power-of-two DEPTH still rolls over to 0.
  assign cur_inc = (cur_addr == AW'(DEPTH - 1)) ? '0 : cur_addr + AW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cur_addr    <= '0;
      remaining   <= '0;
      cmd_ready   <= 1'b0;
      wdata_ready <= 1'b0;
      busy        <= 1'b0;
      rdata_valid <= 1'b0;
      rdata_last  <= 1'b0;
      rdata       <= '0;
      ram_cs      <= 1'b0;
      ram_wr_en   <= 1'b0;
      ram_out_en  <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
    end else begin
      ram_cs     <= 1'b0;
      ram_wr_en  <= 1'b0;
      ram_out_en <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cur_addr  <= cmd_addr;
            remaining <= cmd_len;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (cmd_write) begin
              state       <= W_DATA;
              wdata_ready <= 1'b1;
            end else begin
              state      <= R_ISSUE;
              ram_cs     <= 1'b1;
              ram_out_en <= 1'b1;
              ram_addr   <= cmd_addr;
            end
          end
        end
        W_DATA: begin
          if (wdata_valid) begin
            ram_cs    <= 1'b1;
            ram_wr_en <= 1'b1;
            ram_addr  <= cur_addr;
            ram_wdata <= wdata;
            cur_addr  <= cur_inc;
            if (remaining == '0) begin
              state       <= IDLE;
              wdata_ready <= 1'b0;
              busy        <= 1'b0;
              cmd_ready   <= 1'b1;
            end else begin
              remaining <= remaining - LEN_W'(1);
            end
          end
        end
        R_ISSUE: state <= R_CAP;
        R_CAP: begin
          rdata       <= ram_rdata;
          rdata_valid <= 1'b1;
          rdata_last  <= (remaining == '0);
          state       <= R_RSP;
        end
        R_RSP: begin
          if (rdata_ready) begin
            rdata_valid <= 1'b0;
            rdata_last  <= 1'b0;
            if (remaining != '0) begin
              remaining  <= remaining - LEN_W'(1);
              cur_addr   <= cur_inc;
              ram_cs     <= 1'b1;
              ram_out_en <= 1'b1;
              ram_addr   <= cur_inc;
              state      <= R_ISSUE;
            end else begin
              state     <= IDLE;
              busy      <= 1'b0;
              cmd_ready <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_burst_master.sv
// Directed and randomised bench for ram_burst_master against a behavioural
// registered-read RAM and a reference memory array.
module tb_ram_burst_master;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [5:0] cmd_addr = '0, cmd_len = '0;
  logic       wdata_valid = 1'b0, wdata_ready;
  logic [7:0] wdata = '0;
  logic       rdata_valid, rdata_ready = 1'b0, rdata_last;
  logic [7:0] rdata;
  logic       busy, ram_cs, ram_wr_en, ram_out_en;
  logic [5:0] ram_addr;
  logic [7:0] ram_wdata, ram_rdata;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [64];
  logic [7:0] ref_mem [64];
  logic [7:0] wbuf [64];
  logic [7:0] rd_q = '0;
  logic       rd_v = 1'b0;

  always #5 clk = ~clk;

  ram_burst_master dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .rdata_last(rdata_last), .busy(busy),
    .ram_cs(ram_cs), .ram_wr_en(ram_wr_en), .ram_out_en(ram_out_en),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Registered-read RAM; a junk pattern stands in for the undriven bus.
  always @(posedge clk) begin
    if (ram_cs && ram_wr_en) mem[ram_addr] <= ram_wdata;
    if (ram_cs && ram_out_en) rd_q <= mem[ram_addr];
    rd_v <= ram_cs && ram_out_en && !ram_wr_en;
  end
  assign ram_rdata = rd_v ? rd_q : 8'hEE;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("excl_wr_oe", {31'd0, ram_wr_en & ram_out_en}, 0);
    check("cs_off_strobe", {31'd0, !ram_cs & (ram_wr_en | ram_out_en)}, 0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [5:0] addr, input int len, input int delay);
    int n;
    logic [5:0] a;
    $display("WR addr=%02h len=%0d delay=%0d", addr, len, delay);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = addr; cmd_len = 6'(len);
    n = 0;
    while (!cmd_ready && n < 20) begin step(); n++; end
    check("wr_cmd_ready", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    check("wr_wdata_ready", wdata_ready, 1);
    check("wr_busy", busy, 1);
    check("wr_cmd_ready_low", cmd_ready, 0);
    for (int d = 0; d < delay; d++) begin
      step();
      check("wr_wait_cs", ram_cs, 0);
    end
    a = addr;
    for (int b = 0; b <= len; b++) begin
      wdata_valid = 1'b1;
      wdata = wbuf[b];
      step();
      check("wr_cs", ram_cs, 1);
      check("wr_we", ram_wr_en, 1);
      check("wr_addr", ram_addr, a);
      check("wr_data", ram_wdata, wbuf[b]);
      ref_mem[a] = wbuf[b];
      a = a + 6'd1;
    end
    wdata_valid = 1'b0;
    check("wr_end_busy", busy, 0);
    check("wr_end_cmd_ready", cmd_ready, 1);
    check("wr_end_wready", wdata_ready, 0);
    step();
    check("wr_strobe_end", ram_cs, 0);
  endtask

  task automatic do_read(input logic [5:0] addr, input int len, input int stall_beat, input int stall_cycles);
    int n;
    logic [5:0] a;
    $display("RD addr=%02h len=%0d stall_beat=%0d stall=%0d", addr, len, stall_beat, stall_cycles);
    rdata_ready = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = addr; cmd_len = 6'(len);
    n = 0;
    while (!cmd_ready && n < 20) begin step(); n++; end
    check("rd_cmd_ready", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    a = addr;
    check("rd_issue_cs", ram_cs, 1);
    check("rd_issue_oe", ram_out_en, 1);
    check("rd_issue_addr", ram_addr, a);
    for (int b = 0; b <= len; b++) begin
      n = 0;
      while (!rdata_valid && n < 20) begin step(); n++; end
      check("rd_latency", n, 2);
      check("rd_data", rdata, ref_mem[a]);
      check("rd_last", rdata_last, (b == len) ? 1 : 0);
      if (b == stall_beat) begin
        for (int s = 0; s < stall_cycles; s++) begin
          rdata_ready = 1'b0;
          step();
          check("rd_hold_valid", rdata_valid, 1);
          check("rd_hold_data", rdata, ref_mem[a]);
          check("rd_hold_cs", ram_cs, 0);
        end
      end
      rdata_ready = 1'b1;
      step();
      check("rd_valid_drop", rdata_valid, 0);
      a = a + 6'd1;
      if (b < len) begin
        check("rd_next_cs", ram_cs, 1);
        check("rd_next_addr", ram_addr, a);
      end
    end
    check("rd_end_busy", busy, 0);
    check("rd_end_cmd_ready", cmd_ready, 1);
    rdata_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "bench did not finish");
  end

  initial begin
    #1;
    repeat (2) step();
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_cs", ram_cs, 0);
    check("rst_wready", wdata_ready, 0);
    check("rst_rvalid", rdata_valid, 0);
    check("rst_addr", ram_addr, 0);
    rst_n = 1'b1;
    step();
    check("post_rst_cmd_ready", cmd_ready, 1);

    // Wrapping write then read back, then a stalled read.
    for (int i = 0; i < 4; i++) wbuf[i] = 8'hA0 + 8'(i);
    do_write(6'h3E, 3, 0);
    do_read(6'h3E, 3, -1, 0);
    do_read(6'h3E, 3, 1, 5);

    // Single beat arriving late.
    wbuf[0] = 8'h77;
    do_write(6'h20, 0, 4);
    do_read(6'h20, 0, -1, 0);

    // Preload, then reset during beat 2 of a 4-beat overwrite.
    for (int i = 0; i < 4; i++) wbuf[i] = 8'h50 + 8'(i);
    do_write(6'h10, 3, 0);
    $display("WR addr=10 len=3 reset at beat 2");
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 6'h10; cmd_len = 6'd3;
    step();
    cmd_valid = 1'b0;
    wdata_valid = 1'b1;
    for (int b = 0; b < 3; b++) begin
      wdata = 8'hC0 + 8'(b);
      step();
    end
    rst_n = 1'b0;
    wdata_valid = 1'b0;
    #1;
    check("mid_rst_cs", ram_cs, 0);
    check("mid_rst_we", ram_wr_en, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_wready", wdata_ready, 0);
    check("mid_rst_addr", ram_addr, 0);
    ref_mem[6'h10] = 8'hC0;
    ref_mem[6'h11] = 8'hC1;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    do_read(6'h10, 3, -1, 0);

    // Randomised mix with backpressure.
    for (int i = 0; i < 12; i++) begin
      int len;
      logic [5:0] addr;
      len = $urandom_range(0, 5);
      addr = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k <= len; k++) wbuf[k] = 8'($urandom_range(0, 255));
        do_write(addr, len, $urandom_range(0, 3));
      end else begin
        do_read(addr, len, $urandom_range(0, len), $urandom_range(0, 3));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
